// File: rtl/ysyx_23060124_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_23060124_pkg
//   Shared definitions for the instruction fetch unit:
//     - FSM state encoding (2 bits): S_AR, S_R, S_OUT, S_WB
//     - RESET_PC_DEFAULT : architectural PC after reset
//     - RESP_OKAY        : AXI "OKAY" response code; anything else is an error
//     - word_align()     : clears the two byte-offset bits of an address
// -----------------------------------------------------------------------------
package ysyx_23060124_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_AR  = 2'd0;  // issue read address
   localparam state_t S_R   = 2'd1;  // wait for read data
   localparam state_t S_OUT = 2'd2;  // offer {pc, inst} to decode
   localparam state_t S_WB  = 2'd3;  // wait for write-back to retire

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [1:0]  RESP_OKAY        = 2'b00;

   // Memory is word-addressed for instruction fetch; byte offset is dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ysyx_23060124_ifu.sv
// -----------------------------------------------------------------------------
// ysyx_23060124_ifu
//   Instruction fetch unit. Holds the architectural PC, fetches one 32-bit
//   instruction per retirement over an AXI4-Lite read channel and offers
//   {pc, inst, fetch_err} to decode with a valid/ready handshake. Exactly one
//   instruction is in flight: a new fetch starts only after write-back pulses
//   i_pc_update.
//
//   Ports
//     clk, rst            clock; synchronous active-high reset
//     i_pc_update         write-back retired an instruction (1-cycle pulse)
//     i_pc_next           next PC, valid with i_pc_update
//     o_araddr/o_arvalid  AXI AR channel (address is the word-aligned PC)
//     i_arready
//     i_rdata/i_rresp     AXI R channel
//     i_rvalid/o_rready
//     o_post_valid        {o_pc, o_inst, o_fetch_err} valid to decode
//     i_post_ready        decode accepts
//     o_pc, o_inst        held PC / instruction (hold value outside S_OUT)
//     o_fetch_err         held instruction returned a non-OKAY response
// -----------------------------------------------------------------------------
module ysyx_23060124_ifu
   import ysyx_23060124_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   // write-back side
   input  logic              i_pc_update,
   input  logic [DATA_W-1:0] i_pc_next,
   // AXI4-Lite read address channel
   output logic [DATA_W-1:0] o_araddr,
   output logic              o_arvalid,
   input  logic              i_arready,
   // AXI4-Lite read data channel
   input  logic [DATA_W-1:0] i_rdata,
   input  logic [1:0]        i_rresp,
   input  logic              i_rvalid,
   output logic              o_rready,
   // decode side
   output logic              o_post_valid,
   input  logic              i_post_ready,
   output logic [DATA_W-1:0] o_pc,
   output logic [DATA_W-1:0] o_inst,
   output logic              o_fetch_err
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] pc_q,    pc_d;
   logic [DATA_W-1:0] inst_q,  inst_d;
   logic              err_q,   err_d;

   // Handshake qualifiers, each only meaningful in its own state.
   logic ar_fire;
   logic r_fire;
   logic post_fire;
   logic retire;

   assign ar_fire   = (state_q == S_AR)  && i_arready;
   assign r_fire    = (state_q == S_R)   && i_rvalid;
   assign post_fire = (state_q == S_OUT) && i_post_ready;
   // A pc_update outside S_WB is a protocol violation and is ignored.
   assign retire    = (state_q == S_WB)  && i_pc_update;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge value of every other register, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_AR;
      else     state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: state_d is given a default before the case so no path leaves it
   // unassigned; without it synthesis would infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_AR:  if (ar_fire)   state_d = S_R;
         S_R:   if (r_fire)    state_d = S_OUT;
         S_OUT: if (post_fire) state_d = S_WB;
         S_WB:  if (retire)    state_d = S_AR;
         default:              state_d = S_AR;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs (pure decode of the registered state, so no combinational
   // path from any input to any valid/ready output)
   // ---------------------------------------------------------------------------
   always_comb begin
      o_arvalid    = 1'b0;
      o_rready     = 1'b0;
      o_post_valid = 1'b0;
      unique case (state_q)
         S_AR:    o_arvalid    = 1'b1;
         S_R:     o_rready     = 1'b1;
         S_OUT:   o_post_valid = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      pc_d   = pc_q;
      inst_d = inst_q;
      err_d  = err_q;
      // PC keeps whatever low bits write-back handed us; only the bus address
      // is aligned. Misalignment is the trap logic's business, not ours.
      if (retire) pc_d = i_pc_next;
      if (r_fire) begin
         inst_d = i_rdata;
         err_d  = (i_rresp != RESP_OKAY);
      end
   end

   // NOTE: inst/fetch_err are reset too, even though they are qualified by
   // o_post_valid, so the outputs are deterministic from the first cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         inst_q <= '0;
         err_q  <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         inst_q <= inst_d;
         err_q  <= err_d;
      end
   end

   assign o_araddr    = word_align(pc_q);
   assign o_pc        = pc_q;
   assign o_inst      = inst_q;
   assign o_fetch_err = err_q;

endmodule

// File: tb/tb_ysyx_23060124_ifu.sv
// -----------------------------------------------------------------------------
// tb_ysyx_23060124_ifu
//   Self-checking bench for the instruction fetch unit. The bench plays both
//   the memory and the decode/write-back neighbours. Its reference model is a
//   transaction view of one fetch: address outstanding -> data outstanding ->
//   instruction offered -> awaiting retirement, plus the architectural PC and
//   the last captured instruction. Every cycle all outputs are compared with
//   what that view predicts; directed sequences add explicit constant checks.
// -----------------------------------------------------------------------------
module tb_ysyx_23060124_ifu;

   logic        clk;
   logic        rst;
   logic        i_pc_update;
   logic [31:0] i_pc_next;
   logic [31:0] o_araddr;
   logic        o_arvalid;
   logic        i_arready;
   logic [31:0] i_rdata;
   logic [1:0]  i_rresp;
   logic        i_rvalid;
   logic        o_rready;
   logic        o_post_valid;
   logic        i_post_ready;
   logic [31:0] o_pc;
   logic [31:0] o_inst;
   logic        o_fetch_err;

   ysyx_23060124_ifu dut (
      .clk          (clk),
      .rst          (rst),
      .i_pc_update  (i_pc_update),
      .i_pc_next    (i_pc_next),
      .o_araddr     (o_araddr),
      .o_arvalid    (o_arvalid),
      .i_arready    (i_arready),
      .i_rdata      (i_rdata),
      .i_rresp      (i_rresp),
      .i_rvalid     (i_rvalid),
      .o_rready     (o_rready),
      .o_post_valid (o_post_valid),
      .i_post_ready (i_post_ready),
      .o_pc         (o_pc),
      .o_inst       (o_inst),
      .o_fetch_err  (o_fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_stray  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_pc;
   logic [31:0] m_inst;
   logic        m_err;
   logic        m_need_addr;  // read address not yet accepted
   logic        m_need_data;  // address accepted, data not yet returned
   logic        m_holding;    // instruction offered to decode

   function automatic logic m_awaiting();
      return !m_need_addr && !m_need_data && !m_holding;
   endfunction

   // Applies the effect of the clock edge that just happened, from the inputs
   // the bench held across it.
   task automatic model_update();
      if (rst) begin
         m_pc        = 32'h8000_0000;
         m_inst      = 32'h0;
         m_err       = 1'b0;
         m_need_addr = 1'b1;
         m_need_data = 1'b0;
         m_holding   = 1'b0;
      end else if (m_need_addr) begin
         if (i_arready) begin
            m_need_addr = 1'b0;
            m_need_data = 1'b1;
         end
      end else if (m_need_data) begin
         if (i_rvalid) begin
            m_need_data = 1'b0;
            m_holding   = 1'b1;
            m_inst      = i_rdata;
            m_err       = (i_rresp != 2'b00);
         end
      end else if (m_holding) begin
         if (i_post_ready) m_holding = 1'b0;
      end else if (i_pc_update) begin
         m_pc        = i_pc_next;
         m_need_addr = 1'b1;
      end
   endtask

   task automatic check_outputs();
      check("arvalid",    32'(o_arvalid),    32'(m_need_addr));
      check("rready",     32'(o_rready),     32'(m_need_data));
      check("post_valid", 32'(o_post_valid), 32'(m_holding));
      check("araddr",     o_araddr,          {m_pc[31:2], 2'b00});
      check("pc",         o_pc,              m_pc);
      check("inst",       o_inst,            m_inst);
      check("fetch_err",  32'(o_fetch_err),  32'(m_err));
   endtask

   // One clock: drive inputs, let the edge pass, update model, sample at negedge.
   task automatic step(input logic r, input logic arr, input logic rv,
                       input logic [31:0] rd, input logic [1:0] rr,
                       input logic pr, input logic pu, input logic [31:0] pn);
      rst          = r;
      i_arready    = arr;
      i_rvalid     = rv;
      i_rdata      = rd;
      i_rresp      = rr;
      i_post_ready = pr;
      i_pc_update  = pu;
      i_pc_next    = pn;
      if (!r && pu && !m_awaiting()) n_stray++;
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_outputs();
   endtask

   // Idle cycle with everything deasserted.
   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      m_pc = 32'h0; m_inst = 32'h0; m_err = 1'b0;
      m_need_addr = 1'b0; m_need_data = 1'b0; m_holding = 1'b0;

      // ---- reset ----
      step(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      check("rst_araddr",     o_araddr,            32'h8000_0000);
      check("rst_arvalid",    32'(o_arvalid),      32'd1);
      check("rst_post_valid", 32'(o_post_valid),   32'd0);
      check("rst_inst",       o_inst,              32'h0);

      // ---- zero-wait fetch: handshake cycle, R cycle, post_valid 3rd cycle ----
      step(1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      check("zw_rready", 32'(o_rready), 32'd1);
      step(1'b0, 1'b0, 1'b1, 32'h0000_0413, 2'b00, 1'b0, 1'b0, 32'h0);
      check("zw_post_valid", 32'(o_post_valid), 32'd1);
      check("zw_pc",         o_pc,              32'h8000_0000);
      check("zw_inst",       o_inst,            32'h0000_0413);

      // ---- back-pressure: 5 cycles held, accepted on the 6th ----
      for (int i = 0; i < 5; i++) begin
         idle();
         check("bp_post_valid", 32'(o_post_valid), 32'd1);
         check("bp_inst",       o_inst,            32'h0000_0413);
      end
      step(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0);
      check("bp_accepted", 32'(o_post_valid), 32'd0);

      // ---- redirect ----
      step(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h8000_0100);
      check("rd_araddr", o_araddr, 32'h8000_0100);

      // ---- slow memory + error response ----
      for (int i = 0; i < 4; i++) begin
         idle();
         check("slow_arvalid", 32'(o_arvalid), 32'd1);
         check("slow_araddr",  o_araddr,       32'h8000_0100);
      end
      step(1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         idle();
         check("slow_rready",  32'(o_rready),  32'd1);
         check("slow_no_ar",   32'(o_arvalid), 32'd0);
      end
      step(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, 32'h0);
      check("err_post_valid", 32'(o_post_valid), 32'd1);
      check("err_flag",       32'(o_fetch_err),  32'd1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0);

      // ---- misaligned next PC; next fetch clears the error ----
      step(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h8000_0102);
      check("mis_araddr", o_araddr, 32'h8000_0100);
      check("mis_pc",     o_pc,     32'h8000_0102);
      step(1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'h0010_0093, 2'b00, 1'b0, 1'b0, 32'h0);
      check("clr_err",   32'(o_fetch_err), 32'd0);
      check("clr_inst",  o_inst,           32'h0010_0093);
      step(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0);

      // ---- reset in S_R, then stray pc_update and stray R beat in S_AR ----
      step(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h8000_0200);
      step(1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      check("sr_in_r", 32'(o_rready), 32'd1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      check("sr_arvalid",    32'(o_arvalid),    32'd1);
      check("sr_araddr",     o_araddr,          32'h8000_0000);
      check("sr_post_valid", 32'(o_post_valid), 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h1234_5678);
      check("stray_pc", o_pc, 32'h8000_0000);
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 2'b00, 1'b0, 1'b0, 32'h0);
      check("stray_r_dropped", 32'(o_post_valid), 32'd0);

      // ---- reset in S_OUT ----
      step(1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'h0000_0013, 2'b00, 1'b0, 1'b0, 32'h0);
      check("so_in_out", 32'(o_post_valid), 32'd1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      check("so_post_valid", 32'(o_post_valid), 32'd0);
      check("so_pc",         o_pc,              32'h8000_0000);
      check("so_arvalid",    32'(o_arvalid),    32'd1);

      // ---- randomized traffic against the model ----
      for (int n = 0; n < 4000; n++) begin
         logic        r, arr, rv, pr, pu;
         logic [31:0] rd, pn;
         logic [1:0]  rr;
         r   = ($urandom_range(0, 63) == 0);
         arr = ($urandom_range(0, 2) == 0);
         if (m_need_data) rv = ($urandom_range(0, 2) == 0);
         else             rv = m_need_addr && ($urandom_range(0, 7) == 0);
         rd  = $urandom;
         rr  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         pr  = ($urandom_range(0, 2) != 0);
         if (m_awaiting()) pu = ($urandom_range(0, 1) == 0);
         else              pu = ($urandom_range(0, 15) == 0);
         pn  = ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd4;
         step(r, arr, rv, rd, rr, pr, pu, pn);
      end

      $display("Stray pc_update pulses driven: %0d", n_stray);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
